mina_turn_ctrl: RTL

Turn sequencer for the minesweeper game datapath. It sits between the player buttons and the game state machine, which supplies start_game and consumes bomb/win. It moves a board cursor and, on each play request, reads the external mine map: first the centre cell, then its 8 neighbours. It writes the adjacent-mine count to the display buffer, tracks revealed cells, and pulses bomb or win.

---
 rtl/mina_pkg.sv | 41 ++++
 rtl/mina_turn_cursor.sv | 57 +++++
 rtl/mina_turn_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mina_pkg.sv
// Shared types and constants for the minesweeper turn sequencer.
package mina_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_CMD,
    CENTER,
    SCAN,
    WRITE,
    CHECK,
    LOCK
  } state_e;

  localparam int unsigned MAX_COUNT = 8;
  localparam int unsigned COUNT_W   = $clog2(MAX_COUNT + 1);
  localparam int unsigned NUM_NB    = 8;
  localparam int unsigned PH_W      = 4;

  typedef struct packed {
    logic signed [1:0] dr;
    logic signed [1:0] dc;
  } nb_off_t;

  // Neighbour read order: NW, N, NE, W, E, SW, S, SE.
  function automatic nb_off_t nb_off(input logic [2:0] idx);
    nb_off_t o;
    o = '0;
    case (idx)
      3'd0: o = '{dr: -2'sd1, dc: -2'sd1};
      3'd1: o = '{dr: -2'sd1, dc:  2'sd0};
      3'd2: o = '{dr: -2'sd1, dc:  2'sd1};
      3'd3: o = '{dr:  2'sd0, dc: -2'sd1};
      3'd4: o = '{dr:  2'sd0, dc:  2'sd1};
      3'd5: o = '{dr:  2'sd1, dc: -2'sd1};
      3'd6: o = '{dr:  2'sd1, dc:  2'sd0};
      default: o = '{dr: 2'sd1, dc: 2'sd1};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/mina_turn_cursor.sv
// Board cursor: saturating row/column with up>down>left>right priority.
module mina_cursor
  import mina_pkg::*;
#(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  localparam int ROW_W = $clog2(ROWS),
  localparam int COL_W = $clog2(COLS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             mv_en_i,
  input  logic             up_i,
  input  logic             down_i,
  input  logic             left_i,
  input  logic             right_i,
  output logic [ROW_W-1:0] row_o,
  output logic [COL_W-1:0] col_o
);

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (load_i) begin
      row_d = '0;
      col_d = '0;
    end else if (mv_en_i) begin
      if (up_i) begin
        if (row_q != '0) row_d = row_q - 1'b1;
      end else if (down_i) begin
        if (row_q != ROW_W'(ROWS - 1)) row_d = row_q + 1'b1;
      end else if (left_i) begin
        if (col_q != '0) col_d = col_q - 1'b1;
      end else if (right_i) begin
        if (col_q != COL_W'(COLS - 1)) col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o = row_q;
  assign col_o = col_q;

endmodule

// File: rtl/mina_turn_ctrl.sv
// Turn sequencer: cursor handling, centre+8-neighbour mine-map scan, reveal bookkeeping.
module mina_turn_ctrl
  import mina_pkg::*;
#(
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int NUM_BOMBS = 10,
  localparam int ROW_W  = $clog2(ROWS),
  localparam int COL_W  = $clog2(COLS),
  localparam int ADDR_W = $clog2(ROWS * COLS),
  localparam int CNT_W  = $clog2(ROWS * COLS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               mv_up,
  input  logic               mv_down,
  input  logic               mv_left,
  input  logic               mv_right,
  input  logic               play,
  input  logic               map_data,
  output logic               map_rd,
  output logic [ADDR_W-1:0]  map_addr,
  output logic               cell_we,
  output logic [ADDR_W-1:0]  cell_addr,
  output logic [COUNT_W-1:0] cell_count,
  output logic [ROW_W-1:0]   cur_row,
  output logic [COL_W-1:0]   cur_col,
  output logic [CNT_W-1:0]   revealed_cnt,
  output logic               busy,
  output logic               bomb,
  output logic               win
);

  localparam int unsigned TARGET = ROWS * COLS - NUM_BOMBS;

  state_e               state_q;
  logic [PH_W-1:0]      ph_q;
  logic [ROW_W-1:0]     cen_r_q;
  logic [COL_W-1:0]     cen_c_q;
  logic [ADDR_W-1:0]    cen_addr_q;
  logic [COUNT_W-1:0]   acc_q;
  logic                 rd_dly_q;
  logic [ROWS*COLS-1:0] revealed_q;
  logic                 map_rd_q, cell_we_q, busy_q, bomb_q, win_q;
  logic [ADDR_W-1:0]    map_addr_q, cell_addr_q;
  logic [COUNT_W-1:0]   cell_count_q;
  logic [CNT_W-1:0]     revealed_cnt_q;

  logic [ADDR_W-1:0]    cur_addr;
  logic                 accept;
  logic [PH_W-1:0]      ph_m1;
  nb_off_t              off;
  int                   nr, nc;
  logic                 nb_ok;
  logic [ADDR_W-1:0]    nb_addr;
  logic [COUNT_W-1:0]   nb_bit;
  logic [CNT_W-1:0]     cnt_inc;

  assign cur_addr = ADDR_W'(int'(cur_row) * COLS + int'(cur_col));
  assign accept   = (state_q == WAIT_CMD) && play && !revealed_q[cur_addr];
  assign cnt_inc  = revealed_cnt_q + 1'b1;
  // Data for the read issued last cycle; out-of-bounds slots never contribute.
  assign nb_bit   = COUNT_W'(map_data & rd_dly_q);

  // Address of the neighbour whose read is issued at the coming edge.
  always_comb begin
    ph_m1   = ph_q - 1'b1;
    off     = nb_off(ph_m1[2:0]);
    nr      = int'(cen_r_q) + int'($signed(off.dr));
    nc      = int'(cen_c_q) + int'($signed(off.dc));
    nb_ok   = (nr >= 0) && (nr < ROWS) && (nc >= 0) && (nc < COLS);
    nb_addr = ADDR_W'(nr * COLS + nc);
  end

  mina_cursor #(.ROWS(ROWS), .COLS(COLS)) u_cursor (
    .clk    (clk),
    .rst    (rst),
    .load_i ((state_q == IDLE) && enable),
    .mv_en_i((state_q == WAIT_CMD) && enable && !accept),
    .up_i   (mv_up),
    .down_i (mv_down),
    .left_i (mv_left),
    .right_i(mv_right),
    .row_o  (cur_row),
    .col_o  (cur_col)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      ph_q           <= '0;
      cen_r_q        <= '0;
      cen_c_q        <= '0;
      cen_addr_q     <= '0;
      acc_q          <= '0;
      rd_dly_q       <= 1'b0;
      revealed_q     <= '0;
      map_rd_q       <= 1'b0;
      map_addr_q     <= '0;
      cell_we_q      <= 1'b0;
      cell_addr_q    <= '0;
      cell_count_q   <= '0;
      revealed_cnt_q <= '0;
      busy_q         <= 1'b0;
      bomb_q         <= 1'b0;
      win_q          <= 1'b0;
    end else if (!enable) begin
      state_q   <= IDLE;
      map_rd_q  <= 1'b0;
      rd_dly_q  <= 1'b0;
      cell_we_q <= 1'b0;
      busy_q    <= 1'b0;
      bomb_q    <= 1'b0;
      win_q     <= 1'b0;
    end else begin
      rd_dly_q <= map_rd_q;
      case (state_q)
        IDLE: begin
          state_q        <= WAIT_CMD;
          revealed_q     <= '0;
          revealed_cnt_q <= '0;
        end
        WAIT_CMD: begin
          if (accept) begin
            state_q    <= CENTER;
            busy_q     <= 1'b1;
            map_rd_q   <= 1'b1;
            map_addr_q <= cur_addr;
            cen_r_q    <= cur_row;
            cen_c_q    <= cur_col;
            cen_addr_q <= cur_addr;
            ph_q       <= PH_W'(1);
            acc_q      <= '0;
          end
        end
        CENTER: begin
          state_q  <= SCAN;
          ph_q     <= ph_q + 1'b1;
          map_rd_q <= nb_ok;
          if (nb_ok) map_addr_q <= nb_addr;
        end
        SCAN: begin
          ph_q <= ph_q + 1'b1;
          if (ph_q == PH_W'(2) && map_data) begin
            state_q  <= LOCK;
            bomb_q   <= 1'b1;
            busy_q   <= 1'b0;
            map_rd_q <= 1'b0;
          end else begin
            if (ph_q >= PH_W'(3)) acc_q <= acc_q + nb_bit;
            if (ph_q <= PH_W'(8)) begin
              map_rd_q <= nb_ok;
              if (nb_ok) map_addr_q <= nb_addr;
            end else begin
              map_rd_q <= 1'b0;
            end
            if (ph_q == PH_W'(10)) begin
              state_q      <= WRITE;
              cell_we_q    <= 1'b1;
              cell_addr_q  <= cen_addr_q;
              cell_count_q <= acc_q + nb_bit;
            end
          end
        end
        WRITE: begin
          state_q                <= CHECK;
          cell_we_q              <= 1'b0;
          busy_q                 <= 1'b0;
          revealed_q[cen_addr_q] <= 1'b1;
          revealed_cnt_q         <= cnt_inc;
          win_q                  <= (cnt_inc == CNT_W'(TARGET));
        end
        CHECK: begin
          win_q   <= 1'b0;
          state_q <= win_q ? LOCK : WAIT_CMD;
        end
        default: begin
          bomb_q <= 1'b0;
          win_q  <= 1'b0;
        end
      endcase
    end
  end

  assign map_rd       = map_rd_q;
  assign map_addr     = map_addr_q;
  assign cell_we      = cell_we_q;
  assign cell_addr    = cell_addr_q;
  assign cell_count   = cell_count_q;
  assign revealed_cnt = revealed_cnt_q;
  assign busy         = busy_q;
  assign bomb         = bomb_q;
  assign win          = win_q;

endmodule
